// File: rtl/single_port_ram_64x8.sv
// Single-port synchronous RAM, 64 x 8, flip-flop storage so reset can clear it.
// Writes are write-first; reads return registered data one cycle after the address.
module single_port_ram_64x8 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] output_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] output_data_q;
  logic [DATA_WIDTH-1:0] output_data_d;

  always_comb begin
    mem_d         = mem_q;
    output_data_d = output_data_q;
    if (we) begin
      mem_d[address] = input_data;
      output_data_d  = input_data;
    end else begin
      output_data_d  = mem_q[address];
    end
  end

  // Reset wins over a simultaneous write, so the write is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q         <= '{default: '0};
      output_data_q <= '0;
    end else begin
      mem_q         <= mem_d;
      output_data_q <= output_data_d;
    end
  end

  assign output_data = output_data_q;

endmodule

// File: tb/tb_single_port_ram_64x8.sv
// Directed and randomized bench for single_port_ram_64x8 using an expected-value queue.
module tb_single_port_ram_64x8;

  logic       clk;
  logic       rst;
  logic [7:0] input_data;
  logic [5:0] address;
  logic       we;
  logic [7:0] output_data;

  int checks;
  int errors;

  logic [7:0] model [64];
  logic [7:0] exp_q [$];
  string      tag_q [$];

  single_port_ram_64x8 dut (
    .clk         (clk),
    .rst         (rst),
    .input_data  (input_data),
    .address     (address),
    .we          (we),
    .output_data (output_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge of activity: drive at negedge, predict, compare after posedge.
  task automatic step(input logic r, input logic w, input logic [5:0] a,
                      input logic [7:0] d, input string tag);
    logic [7:0] e;
    @(negedge clk);
    rst        = r;
    we         = w;
    address    = a;
    input_data = d;
    if (r) begin
      for (int i = 0; i < 64; i++) model[i] = 8'h00;
      e = 8'h00;
    end else if (w) begin
      model[a] = d;
      e = d;
    end else begin
      e = model[a];
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s observed=empty-queue expected=entry", tag);
    end else begin
      check(tag_q.pop_front(), output_data, exp_q.pop_front());
    end
  endtask

  initial begin
    logic [5:0] ra;
    logic [5:0] ra2;
    logic [7:0] rd;
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    we         = 1'b0;
    address    = '0;
    input_data = '0;
    for (int i = 0; i < 64; i++) model[i] = 8'h00;

    step(1'b1, 1'b0, 6'd0, 8'h00, "reset_out");
    step(1'b0, 1'b0, 6'd0, 8'h00, "rst_rd0");
    step(1'b0, 1'b0, 6'd7, 8'h00, "rst_rd7");
    step(1'b0, 1'b0, 6'd63, 8'h00, "rst_rd63");

    step(1'b0, 1'b1, 6'd7, 8'hAA, "wr7");
    step(1'b0, 1'b1, 6'd10, 8'hFF, "wr10");
    step(1'b0, 1'b0, 6'd7, 8'h00, "rd7");
    step(1'b0, 1'b0, 6'd10, 8'h00, "rd10");

    step(1'b0, 1'b1, 6'd20, 8'h5C, "wf20");
    step(1'b0, 1'b0, 6'd20, 8'h00, "rd20");
    address    = 6'd10;
    we         = 1'b1;
    input_data = 8'h12;
    #2;
    check("hold_between_edges", output_data, 8'h5C);
    we = 1'b0;
    #1;
    check("hold_we_change", output_data, 8'h5C);

    step(1'b0, 1'b1, 6'd0, 8'h01, "wr0");
    step(1'b0, 1'b1, 6'd63, 8'h80, "wr63");
    step(1'b0, 1'b0, 6'd0, 8'h00, "rd0");
    step(1'b0, 1'b0, 6'd63, 8'h00, "rd63");
    step(1'b0, 1'b0, 6'd7, 8'h00, "iso_rd7");
    step(1'b0, 1'b1, 6'd7, 8'h33, "ow7");
    step(1'b0, 1'b0, 6'd7, 8'h00, "rd7_ow");
    step(1'b0, 1'b0, 6'd10, 8'h00, "rd10_keep");
    step(1'b0, 1'b0, 6'd20, 8'h00, "rd20_keep");

    step(1'b1, 1'b1, 6'd7, 8'h77, "rst_prio");
    step(1'b0, 1'b0, 6'd7, 8'h00, "post_rst7");
    step(1'b0, 1'b0, 6'd10, 8'h00, "post_rst10");
    step(1'b0, 1'b0, 6'd63, 8'h00, "post_rst63");

    for (int i = 0; i < 8; i++) begin
      ra  = 6'($urandom_range(0, 63));
      ra2 = 6'($urandom_range(0, 63));
      rd  = 8'($urandom_range(0, 255));
      step(1'b0, 1'b1, ra, rd, "b2b_wr");
      step(1'b0, 1'b0, ra, 8'h00, "b2b_rd");
      step(1'b0, 1'b0, ra2, 8'h00, "b2b_rd_other");
    end
    for (int i = 0; i < 64; i += 9) begin
      step(1'b0, 1'b0, 6'(i), 8'h00, "sweep_rd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/single_port_ram_64x8.md
Name: single_port_ram_64x8

Overview:
- Single-port synchronous RAM: 64 words x 8 bits, one shared address bus for reads and writes.
- Write enable selects a write; otherwise the cycle is a read.
- Used as a small local scratch/storage buffer inside a single clock domain.
- Storage is implemented in flip-flops so that reset can clear it.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 6, address width in bits.
- DEPTH, 64, number of words; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- input_data  input  DATA_WIDTH  write data.
- address  input  ADDR_WIDTH  word address for both read and write.
- we  input  1  write enable; 1 = write, 0 = read.
- output_data  output  DATA_WIDTH  registered read data.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is synchronous and active-high.
  - rst is sampled only on the rising edge of clk. It has no asynchronous effect.
- Reset (rst=1 at a rising edge):
  - output_data <= 0.
  - All DEPTH locations <= 0.
  - rst has priority over we: no write occurs in a reset cycle.
- Write (rst=0, we=1 at a rising edge):
  - mem[address] <= input_data.
  - Write-first: output_data <= input_data in the same edge.
- Read (rst=0, we=0 at a rising edge):
  - output_data <= mem[address].
  - Latency is 1 cycle: the address presented before edge N gives its data on output_data after edge N, stable until the next edge.
- Read-after-write:
  - A read of address A on the edge after a write to A returns the newly written value.
- Between edges:
  - output_data holds its value. address and we changes have no combinational effect on output_data.
- Addressing:
  - All 2**ADDR_WIDTH addresses are valid. Addresses 0 and 63 are fully usable.
  - No wrap-around logic is needed, because the address width exactly covers the depth.
- Write isolation:
  - A write changes only the addressed location. All other locations keep their contents.
- Power-up:
  - Contents are undefined until the first reset.
  - The bench applies rst before checking any data.
- Reset mid-operation:
  - A reset asserted in a write cycle discards the write.
  - After reset, every location reads back 0.
- No handshake:
  - Every edge performs exactly one operation: reset, write, or read.

Test Plan:
- Reset: rst=1 for 1 edge, then rst=0; read addresses 0, 7, 63 -> output_data=0x00 one cycle after each address is applied.
- Write then read: write 0xAA to addr 7, then 0xFF to addr 10 (we=1, one edge each); we=0, addr=7 -> output_data=0xAA after next edge; addr=10 -> 0xFF after next edge.
- Write-first and latency: we=1, addr=20, data=0x5C -> output_data=0x5C after that edge; we=0, addr=20 -> output_data stays 0x5C; changing address between edges leaves output_data unchanged until the next edge.
- Boundaries and isolation: write 0x01 to addr 0 and 0x80 to addr 63; read 0, 63, 7 -> 0x01, 0x80, 0xAA. Overwrite addr 7 with 0x33; read 7 -> 0x33, read 10 -> 0xFF unchanged.
- Reset priority: with memory loaded, assert rst=1 together with we=1, addr=7, data=0x77 -> output_data=0x00. Then read addr 7 and addr 10 -> both 0x00.
- Back-to-back: alternate writes and reads on consecutive edges across 8 random addresses/data -> every read matches a reference model with exactly 1-cycle latency.
